// File: rtl/clk_gate_ctrl_pkg.sv
// Package for the clock-gate enable controller.
// Holds the FSM state encoding and the helper that sizes the shared
// idle/wake counter from the two timing parameters.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    GS_ON    = 2'd0,
    GS_DRAIN = 2'd1,
    GS_OFF   = 2'd2,
    GS_WAKE  = 2'd3
  } gate_state_e;

  // Counter must reach max(idle_cycles, wake_delay) - 1; sized for the max
  // itself so both terminal values fit. Never returns less than 1 bit.
  function automatic int unsigned cnt_width(int unsigned idle_cycles,
                                            int unsigned wake_delay);
    int unsigned m;
    m = (idle_cycles > wake_delay) ? idle_cycles : wake_delay;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller.
// Sits upstream of the clock-gating cell and drives its enable. Counts
// consecutive idle cycles of the gated domain, runs a sleep request /
// acknowledge handshake, drops the enable only after acknowledge, and on wake
// restores the enable and holds ready low for WakeDelay cycles.
//
// Ports:
//   clk_i        free-running clock (ungated side)
//   rst_ni       asynchronous active-low reset
//   busy_i       gated-domain activity flag
//   wake_req_i   wake request from interrupt/bus logic
//   force_on_i   software override, keeps the clock running
//   sleep_ack_i  domain quiescent acknowledge (sampled only while draining)
//   clk_en_o     enable to the clock-gating cell
//   sleep_req_o  request to the domain to quiesce
//   ready_o      clock running and settled
//   sleeping_o   clock gated off
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned IdleCycles = 16,
  parameter int unsigned WakeDelay  = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic busy_i,
  input  logic wake_req_i,
  input  logic force_on_i,
  input  logic sleep_ack_i,
  output logic clk_en_o,
  output logic sleep_req_o,
  output logic ready_o,
  output logic sleeping_o
);

  localparam int unsigned CntW = cnt_width(IdleCycles, WakeDelay);
  localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeDelay - 1);

  // Elaboration-time parameter checks.
  if (IdleCycles == 0) begin : g_bad_idle
    $fatal(1, "clk_gate_ctrl: IdleCycles must be >= 1");
  end
  if (WakeDelay == 0) begin : g_bad_wake
    $fatal(1, "clk_gate_ctrl: WakeDelay must be >= 1");
  end

  gate_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            idle;

  assign idle = !busy_i && !wake_req_i && !force_on_i;

  // Reset lands in WAKE so the domain clock runs immediately and ready only
  // rises after the normal settling delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GS_WAKE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. The counter is shared by ON (idle run length) and WAKE
  // (settling time) and is cleared on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      GS_ON: begin
        if (!idle) begin
          cnt_d = '0;
        end else if (cnt_q == IdleLast) begin
          state_d = GS_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GS_DRAIN: begin
        // Any activity aborts the drain, even with an ack in the same cycle.
        if (!idle) begin
          state_d = GS_ON;
          cnt_d   = '0;
        end else if (sleep_ack_i) begin
          state_d = GS_OFF;
          cnt_d   = '0;
        end
      end
      GS_OFF: begin
        if (wake_req_i || force_on_i) begin
          state_d = GS_WAKE;
          cnt_d   = '0;
        end
      end
      GS_WAKE: begin
        if (cnt_q == WakeLast) begin
          state_d = GS_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = GS_WAKE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode from the flopped state only, so the gate latch never sees
  // a combinational glitch from the inputs.
  always_comb begin
    clk_en_o    = 1'b1;
    sleep_req_o = 1'b0;
    ready_o     = 1'b0;
    sleeping_o  = 1'b0;
    unique case (state_q)
      GS_ON: begin
        ready_o = 1'b1;
      end
      GS_DRAIN: begin
        sleep_req_o = 1'b1;
      end
      GS_OFF: begin
        clk_en_o   = 1'b0;
        sleeping_o = 1'b1;
      end
      GS_WAKE: begin
        clk_en_o = 1'b1;
      end
      default: begin
        clk_en_o = 1'b1;
      end
    endcase
  end

  // Gate is only ever off while reporting sleep.
  a_en_low_sleeping : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !clk_en_o |-> sleeping_o
  );

  // Upstream is never told it may issue work while a drain is requested.
  a_req_ready_excl : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(sleep_req_o && ready_o)
  );

  // The gate may only close after a completed handshake.
  a_off_from_drain : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (state_d == GS_OFF) |-> (state_q inside {GS_DRAIN, GS_OFF})
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

  localparam int unsigned IdleCycles = 4;
  localparam int unsigned WakeDelay  = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic busy_i = 1'b0;
  logic wake_req_i = 1'b0;
  logic force_on_i = 1'b0;
  logic sleep_ack_i = 1'b0;
  logic clk_en_o, sleep_req_o, ready_o, sleeping_o;

  int tests = 0;
  int fails = 0;

  // Reference model: described in terms of "asleep", "request pending",
  // length of the current idle run and settling cycles still to go.
  bit m_asleep;
  bit m_req;
  int m_idle_run;
  int m_settle;

  clk_gate_ctrl #(
    .IdleCycles(IdleCycles),
    .WakeDelay (WakeDelay)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .busy_i     (busy_i),
    .wake_req_i (wake_req_i),
    .force_on_i (force_on_i),
    .sleep_ack_i(sleep_ack_i),
    .clk_en_o   (clk_en_o),
    .sleep_req_o(sleep_req_o),
    .ready_o    (ready_o),
    .sleeping_o (sleeping_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit m_clk_en();   return !m_asleep; endfunction
  function automatic bit m_ready();    return !m_asleep && !m_req && m_settle == 0; endfunction

  task automatic check_model(input string tag);
    check({tag, ".clk_en"},    clk_en_o,    m_clk_en());
    check({tag, ".sleep_req"}, sleep_req_o, m_req);
    check({tag, ".ready"},     ready_o,     m_ready());
    check({tag, ".sleeping"},  sleeping_o,  m_asleep);
  endtask

  task automatic model_reset();
    m_asleep   = 0;
    m_req      = 0;
    m_idle_run = 0;
    m_settle   = WakeDelay;
  endtask

  task automatic model_edge();
    bit idle;
    idle = !busy_i && !wake_req_i && !force_on_i;
    if (m_asleep) begin
      if (wake_req_i || force_on_i) begin
        m_asleep = 0;
        m_settle = WakeDelay;
      end
    end else if (m_settle > 0) begin
      m_settle--;
      m_idle_run = 0;
    end else if (m_req) begin
      if (!idle) begin
        m_req      = 0;
        m_idle_run = 0;
      end else if (sleep_ack_i) begin
        m_req    = 0;
        m_asleep = 1;
      end
    end else begin
      m_idle_run = idle ? m_idle_run + 1 : 0;
      if (m_idle_run == IdleCycles) begin
        m_req      = 1;
        m_idle_run = 0;
      end
    end
  endtask

  // One clock: model follows the edge, DUT sampled 1 ns later.
  task automatic step(input string tag);
    @(posedge clk_i);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Reset asserted mid-cycle; outputs must change without a clock edge.
  task automatic apply_reset(input string tag);
    #3 rst_ni = 1'b0;
    #1;
    check({tag, ".rst_clk_en"},    clk_en_o,    1'b1);
    check({tag, ".rst_ready"},     ready_o,     1'b0);
    check({tag, ".rst_sleep_req"}, sleep_req_o, 1'b0);
    check({tag, ".rst_sleeping"},  sleeping_o,  1'b0);
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic go_to_off(input string tag);
    repeat (IdleCycles) step(tag);
    sleep_ack_i = 1'b1;
    step(tag);
    sleep_ack_i = 1'b0;
  endtask

  initial begin
    // 1. Reset and release.
    apply_reset("reset");
    step("reset_e1");
    check("reset_ready_e1", ready_o, 1'b0);
    step("reset_e2");
    check("reset_ready_e2", ready_o, 1'b1);

    // 2. Idle entry and handshake.
    repeat (IdleCycles - 1) step("idle");
    check("idle_no_req_yet", sleep_req_o, 1'b0);
    step("idle_last");
    check("idle_req_rise", sleep_req_o, 1'b1);
    sleep_ack_i = 1'b1;
    step("ack");
    sleep_ack_i = 1'b0;
    check("ack_clk_en",   clk_en_o,    1'b0);
    check("ack_sleeping", sleeping_o,  1'b1);
    check("ack_req_low",  sleep_req_o, 1'b0);

    // 5. Wake by wake_req_i pulse, then by force_on_i pulse.
    wake_req_i = 1'b1;
    step("wake_req");
    wake_req_i = 1'b0;
    check("wake_clk_en", clk_en_o, 1'b1);
    step("wake_s1");
    check("wake_ready_s1", ready_o, 1'b0);
    step("wake_s2");
    check("wake_ready_s2", ready_o, 1'b1);
    go_to_off("to_off2");
    check("off2_sleeping", sleeping_o, 1'b1);
    force_on_i = 1'b1;
    step("force_wake");
    force_on_i = 1'b0;
    check("force_clk_en", clk_en_o, 1'b1);
    step("force_s1");
    check("force_ready_s1", ready_o, 1'b0);
    step("force_s2");
    check("force_ready_s2", ready_o, 1'b1);

    // 3. Idle run restarted by a one-cycle busy pulse.
    repeat (IdleCycles - 1) step("restart_pre");
    busy_i = 1'b1;
    step("restart_busy");
    busy_i = 1'b0;
    check("restart_no_req", sleep_req_o, 1'b0);
    repeat (IdleCycles - 1) step("restart_post");
    check("restart_still_low", sleep_req_o, 1'b0);
    step("restart_last");
    check("restart_req_rise", sleep_req_o, 1'b1);

    // 4. Abort beats ack in the same cycle.
    busy_i      = 1'b1;
    sleep_ack_i = 1'b1;
    step("abort");
    busy_i      = 1'b0;
    sleep_ack_i = 1'b0;
    check("abort_clk_en", clk_en_o,    1'b1);
    check("abort_ready",  ready_o,     1'b1);
    check("abort_req",    sleep_req_o, 1'b0);

    // 6. Override holds the clock on; reset in WAKE and in DRAIN.
    force_on_i = 1'b1;
    repeat (100) begin
      step("force_hold");
      check("force_hold_no_req", sleep_req_o, 1'b0);
    end
    force_on_i = 1'b0;
    go_to_off("to_off3");
    wake_req_i = 1'b1;
    step("wake3");
    wake_req_i = 1'b0;
    apply_reset("rst_in_wake");
    step("rst_wake_e1");
    step("rst_wake_e2");
    check("rst_wake_ready", ready_o, 1'b1);
    repeat (IdleCycles) step("to_drain");
    check("drain_before_rst", sleep_req_o, 1'b1);
    apply_reset("rst_in_drain");
    step("rst_drain_e1");
    check("rst_drain_clk_en", clk_en_o, 1'b1);
    step("rst_drain_e2");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      busy_i      = ($urandom_range(4) == 0);
      wake_req_i  = ($urandom_range(9) == 0);
      force_on_i  = ($urandom_range(19) == 0);
      sleep_ack_i = m_req && ($urandom_range(1) == 1);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
